// File: rtl/blake2_compress.sv
// Iterative BLAKE2 compression function F (BLAKE2s for W=32, BLAKE2b for W=64).
// A single combinational G mixer is stepped once per clock over all rounds of a block.
module blake2_compress #(
  parameter int W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [8*W-1:0]  h_i,
  input  logic [16*W-1:0] m_i,
  input  logic [2*W-1:0]  t_i,
  input  logic            f_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [8*W-1:0]  h_o
);

  if (W != 32 && W != 64) begin : g_bad_width
    $error("blake2_compress: W must be 32 or 64");
  end

  localparam int ROUNDS = (W == 64) ? 12 : 10;
  localparam int R1     = (W == 64) ? 32 : 16;
  localparam int R2     = (W == 64) ? 24 : 12;
  localparam int R3     = (W == 64) ? 16 : 8;
  localparam int R4     = (W == 64) ? 63 : 7;
  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

  typedef logic [W-1:0] word_t;
  typedef enum logic [1:0] {IDLE, MIX, DONE} state_t;

  // BLAKE2s IVs are the upper halves of the BLAKE2b IVs.
  localparam logic [63:0] IV64 [8] = '{
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
  };

  // Message schedule, one row per round; entry k of a row is nibble k (LSB first).
  localparam logic [63:0] SIGMA [10] = '{
    64'hFEDCBA9876543210, 64'h357B20C16DF984AE, 64'h491763EADF250C8B, 64'h8F04A562EBCD1397,
    64'hD386CB1EFA427509, 64'h91EF57D438B0A6C2, 64'hB8293670A4DEF15C, 64'hA2684F05931CE7BD,
    64'h5A417D2C803B9EF6, 64'h0DC3E9BF5167482A
  };

  function automatic word_t rotr(input word_t x, input int r);
    return (x >> r) | (x << (W - r));
  endfunction

  state_t     state;
  logic [3:0] round;
  logic [2:0] step;
  word_t      h_r [8];
  word_t      m_r [16];
  word_t      v [16];
  word_t      v_init [16];
  word_t      v_nxt [16];
  logic [3:0] ia, ib, ic, id, sx, sy, rmod;
  logic [63:0] srow;
  word_t      a1, b1, c1, d1, a2, b2, c2, d2;

  assign ready_o = (state == IDLE) && !rst;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      v_init[i]   = h_i[i*W +: W];
      v_init[i+8] = word_t'(IV64[i] >> (64 - W));
    end
    v_init[12] = v_init[12] ^ t_i[W-1:0];
    v_init[13] = v_init[13] ^ t_i[2*W-1:W];
    if (f_i) v_init[14] = ~v_init[14];
  end

  // Steps 0..3 mix columns, 4..7 mix diagonals.
  always_comb begin
    case (step)
      3'd0:    {ia, ib, ic, id} = {4'd0, 4'd4, 4'd8,  4'd12};
      3'd1:    {ia, ib, ic, id} = {4'd1, 4'd5, 4'd9,  4'd13};
      3'd2:    {ia, ib, ic, id} = {4'd2, 4'd6, 4'd10, 4'd14};
      3'd3:    {ia, ib, ic, id} = {4'd3, 4'd7, 4'd11, 4'd15};
      3'd4:    {ia, ib, ic, id} = {4'd0, 4'd5, 4'd10, 4'd15};
      3'd5:    {ia, ib, ic, id} = {4'd1, 4'd6, 4'd11, 4'd12};
      3'd6:    {ia, ib, ic, id} = {4'd2, 4'd7, 4'd8,  4'd13};
      default: {ia, ib, ic, id} = {4'd3, 4'd4, 4'd9,  4'd14};
    endcase
  end

  // NOTE: blocking '=' is right here: each G stage consumes the previous stage's result in the same cycle.
  always_comb begin
    rmod = (round >= 4'd10) ? round - 4'd10 : round;
    srow = SIGMA[rmod];
    sx   = srow[{step, 3'b000} +: 4];
    sy   = srow[{step, 3'b100} +: 4];
    a1 = v[ia] + v[ib] + m_r[sx];
    d1 = rotr(v[id] ^ a1, R1);
    c1 = v[ic] + d1;
    b1 = rotr(v[ib] ^ c1, R2);
    a2 = a1 + b1 + m_r[sy];
    d2 = rotr(d1 ^ a2, R3);
    c2 = c1 + d2;
    b2 = rotr(b1 ^ c2, R4);
    // NOTE: v_nxt starts as a full copy of v so every element is assigned on every path and no latch is inferred.
    v_nxt     = v;
    v_nxt[ia] = a2;
    v_nxt[ib] = b2;
    v_nxt[ic] = c2;
    v_nxt[id] = d2;
  end

  // NOTE: h_r, m_r and v are pure datapath storage, always loaded before use, so they carry no reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      valid_o <= 1'b0;
      h_o     <= '0;
      round   <= '0;
      step    <= '0;
    end else begin
      case (state)
        IDLE: if (valid_i) begin
          for (int i = 0; i < 8; i++)  h_r[i] <= h_i[i*W +: W];
          for (int j = 0; j < 16; j++) m_r[j] <= m_i[j*W +: W];
          v     <= v_init;
          round <= '0;
          step  <= '0;
          state <= MIX;
        end
        MIX: begin
          v    <= v_nxt;
          step <= step + 3'd1;
          if (step == 3'd7) begin
            if (round == LAST_ROUND) begin
              for (int i = 0; i < 8; i++) h_o[i*W +: W] <= h_r[i] ^ v_nxt[i] ^ v_nxt[i+8];
              valid_o <= 1'b1;
              round   <= '0;
              state   <= DONE;
            end else begin
              round <= round + 4'd1;
            end
          end
        end
        DONE: if (ready_i) begin
          valid_o <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_blake2_compress.sv
// Self-checking bench for blake2_compress: BLAKE2s and BLAKE2b instances against a
// transaction-level reference model plus RFC 7693 digest literals.
module tb_blake2_compress;

  typedef logic [7:0][63:0]  h8_t;
  typedef logic [15:0][63:0] m16_t;

  localparam logic [255:0] D_ABC32 = 256'h508C5E8C327C14E2E1A72BA34EEB452F37458B209ED63A294D999B4C86675982;
  localparam logic [255:0] D_EMP32 = 256'h69217A3079908094E11121D042354A7C1F55B6482CA1A51E1B250DFD1ED0EEF9;
  localparam logic [511:0] D_ABC64 = 512'hBA80A53F981C4D0D6A2797B69F12F6E94C212F14685AC4B74B12BB6FDBFFA2D17D87C5392AAB792DC252D5DE4533CC9518D38AA8DBF1925AB92386EDD4009923;

  localparam logic [63:0] IVB [8] = '{
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
  };
  localparam int SIG [10][16] = '{
    '{ 0, 1, 2, 3, 4, 5, 6, 7, 8, 9,10,11,12,13,14,15},
    '{14,10, 4, 8, 9,15,13, 6, 1,12, 0, 2,11, 7, 5, 3},
    '{11, 8,12, 0, 5, 2,15,13,10,14, 3, 6, 7, 1, 9, 4},
    '{ 7, 9, 3, 1,13,12,11,14, 2, 6, 5,10, 4, 0,15, 8},
    '{ 9, 0, 5, 7, 2, 4,10,15,14, 1,11,12, 6, 8, 3,13},
    '{ 2,12, 6,10, 0,11, 8, 3, 4,13, 7, 5,15,14, 1, 9},
    '{12, 5, 1,15,14,13, 4,10, 0, 7, 6, 3, 9, 2, 8,11},
    '{13,11, 7,14,12, 1, 3, 9, 5, 0,15, 4, 8, 6, 2,10},
    '{ 6,15,14, 9,11, 3, 0, 8,12, 2,13, 7, 1, 4,10, 5},
    '{10, 2, 8, 4, 7, 6, 1, 5,15,11, 9,14, 3,12,13, 0}
  };
  localparam int GI [8][4] = '{
    '{0,4,8,12}, '{1,5,9,13}, '{2,6,10,14}, '{3,7,11,15},
    '{0,5,10,15}, '{1,6,11,12}, '{2,7,8,13}, '{3,4,9,14}
  };

  logic clk, rst;
  logic s_valid, s_ready, s_f, s_valid_o, s_ready_i;
  logic [255:0] s_h, s_h_o;
  logic [511:0] s_m;
  logic [63:0]  s_t;
  logic b_valid, b_ready, b_f, b_valid_o, b_ready_i;
  logic [511:0]  b_h, b_h_o;
  logic [1023:0] b_m;
  logic [127:0]  b_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_on = 0;
  int ph [2] = '{0, 0};
  int cnt [2] = '{0, 0};
  h8_t exp_q [2];
  h8_t hold_q [2] = '{'0, '0};

  blake2_compress #(.W(32)) u_s (
    .clk(clk), .rst(rst), .valid_i(s_valid), .ready_o(s_ready), .h_i(s_h), .m_i(s_m),
    .t_i(s_t), .f_i(s_f), .valid_o(s_valid_o), .ready_i(s_ready_i), .h_o(s_h_o)
  );
  blake2_compress #(.W(64)) u_b (
    .clk(clk), .rst(rst), .valid_i(b_valid), .ready_o(b_ready), .h_i(b_h), .m_i(b_m),
    .t_i(b_t), .f_i(b_f), .valid_o(b_valid_o), .ready_i(b_ready_i), .h_o(b_h_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] iv(input int i, input int w);
    return (w == 32) ? (IVB[i] >> 32) : IVB[i];
  endfunction

  function automatic logic [63:0] rotr(input logic [63:0] x, input int r, input int w);
    logic [63:0] mk = (w == 32) ? 64'hFFFF_FFFF : '1;
    return ((x >> r) | (x << (w - r))) & mk;
  endfunction

  // Reference compression F straight from the BLAKE2 definition.
  function automatic h8_t model_f(input h8_t h, input m16_t m, input logic [63:0] tlo,
                                  input logic [63:0] thi, input logic f, input int w);
    logic [63:0] v [16];
    logic [63:0] mk, x, y;
    int nr, r1, r2, r3, r4, a, b, c, d;
    h8_t o;
    mk = (w == 32) ? 64'hFFFF_FFFF : '1;
    nr = (w == 32) ? 10 : 12;
    r1 = (w == 32) ? 16 : 32;
    r2 = (w == 32) ? 12 : 24;
    r3 = (w == 32) ? 8 : 16;
    r4 = (w == 32) ? 7 : 63;
    for (int i = 0; i < 8; i++) begin
      v[i]   = h[i] & mk;
      v[i+8] = iv(i, w);
    end
    v[12] ^= tlo & mk;
    v[13] ^= thi & mk;
    if (f) v[14] ^= mk;
    for (int r = 0; r < nr; r++) begin
      for (int s = 0; s < 8; s++) begin
        a = GI[s][0]; b = GI[s][1]; c = GI[s][2]; d = GI[s][3];
        x = m[SIG[r % 10][2*s]] & mk;
        y = m[SIG[r % 10][2*s+1]] & mk;
        v[a] = (v[a] + v[b] + x) & mk;
        v[d] = rotr(v[d] ^ v[a], r1, w);
        v[c] = (v[c] + v[d]) & mk;
        v[b] = rotr(v[b] ^ v[c], r2, w);
        v[a] = (v[a] + v[b] + y) & mk;
        v[d] = rotr(v[d] ^ v[a], r3, w);
        v[c] = (v[c] + v[d]) & mk;
        v[b] = rotr(v[b] ^ v[c], r4, w);
      end
    end
    for (int i = 0; i < 8; i++) o[i] = (h[i] & mk) ^ v[i] ^ v[i+8];
    return o;
  endfunction

  function automatic h8_t dig_words(input logic [511:0] d, input int nbytes, input int w);
    h8_t o = '0;
    for (int i = 0; i < 8; i++)
      for (int b = 0; b < w / 8; b++)
        o[i][8*b +: 8] = d[(nbytes - 1 - (i * (w / 8) + b)) * 8 +: 8];
    return o;
  endfunction

  function automatic h8_t h_from32(input logic [255:0] p);
    h8_t o = '0;
    for (int i = 0; i < 8; i++) o[i] = {32'h0, p[i*32 +: 32]};
    return o;
  endfunction

  function automatic logic [255:0] h_to32(input h8_t h);
    logic [255:0] o;
    for (int i = 0; i < 8; i++) o[i*32 +: 32] = h[i][31:0];
    return o;
  endfunction

  function automatic m16_t m_from32(input logic [511:0] p);
    m16_t o = '0;
    for (int j = 0; j < 16; j++) o[j] = {32'h0, p[j*32 +: 32]};
    return o;
  endfunction

  function automatic h8_t h_init(input int w);
    h8_t o;
    for (int i = 0; i < 8; i++) o[i] = iv(i, w);
    o[0] ^= (w == 32) ? 64'h01010020 : 64'h01010040;
    return o;
  endfunction

  // Transaction-level timing model: advances one clock edge given the inputs about to be sampled.
  task automatic step_model(input int k, input logic vin, input logic rin, input h8_t h, input m16_t m,
                            input logic [63:0] tlo, input logic [63:0] thi, input logic f, input int w);
    int last = (w == 32) ? 80 : 96;
    if (rst) begin
      ph[k] = 0; cnt[k] = 0; hold_q[k] = '0;
    end else begin
      case (ph[k])
        0: if (vin) begin exp_q[k] = model_f(h, m, tlo, thi, f, w); ph[k] = 1; cnt[k] = 0; end
        1: begin
          cnt[k]++;
          if (cnt[k] == last) begin ph[k] = 2; hold_q[k] = exp_q[k]; end
        end
        default: if (rin) ph[k] = 0;
      endcase
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      check("mon ready32", 512'(s_ready), 512'(ph[0] == 0 && !rst));
      check("mon valid32", 512'(s_valid_o), 512'(ph[0] == 2));
      check("mon h_o32", h_from32(s_h_o), hold_q[0]);
      check("mon ready64", 512'(b_ready), 512'(ph[1] == 0 && !rst));
      check("mon valid64", 512'(b_valid_o), 512'(ph[1] == 2));
      check("mon h_o64", b_h_o, hold_q[1]);
      step_model(0, s_valid, s_ready_i, h_from32(s_h), m_from32(s_m),
                 {32'h0, s_t[31:0]}, {32'h0, s_t[63:32]}, s_f, 32);
      step_model(1, b_valid, b_ready_i, b_h, b_m, b_t[63:0], b_t[127:64], b_f, 64);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send32(input logic [255:0] h, input logic [511:0] m, input logic [63:0] t,
                        input logic f, output int acc);
    int n = 0;
    while (!s_ready && n < 300) begin tick; n++; end
    check("send32 ready", 512'(s_ready), 512'(1));
    s_h = h; s_m = m; s_t = t; s_f = f; s_valid = 1'b1;
    tick;
    acc = cyc;
    s_valid = 1'b0;
    for (int i = 0; i < 8; i++)  s_h[i*32 +: 32] = $urandom;
    for (int j = 0; j < 16; j++) s_m[j*32 +: 32] = $urandom;
    s_t = {$urandom, $urandom};
    s_f = ~f;
  endtask

  task automatic send64(input logic [511:0] h, input logic [1023:0] m, input logic [127:0] t,
                        input logic f);
    int n = 0;
    while (!b_ready && n < 300) begin tick; n++; end
    check("send64 ready", 512'(b_ready), 512'(1));
    b_h = h; b_m = m; b_t = t; b_f = f; b_valid = 1'b1;
    tick;
    b_valid = 1'b0;
    b_h = '1; b_m = '1; b_t = '1; b_f = ~f;
  endtask

  task automatic wait_valid32(output int lat);
    lat = 0;
    while (!s_valid_o && lat < 300) begin tick; lat++; end
  endtask

  task automatic wait_valid64(output int lat);
    lat = 0;
    while (!b_valid_o && lat < 300) begin tick; lat++; end
  endtask

  initial begin
    int lat, acc1, acc2;
    bit quiet;
    h8_t e1, e2;
    logic [511:0] m1, m2;

    rst = 1'b1;
    s_valid = 0; s_h = '0; s_m = '0; s_t = '0; s_f = 0; s_ready_i = 0;
    b_valid = 0; b_h = '0; b_m = '0; b_t = '0; b_f = 0; b_ready_i = 0;
    repeat (3) tick;
    mon_on = 1;

    check("reset ready32", 512'(s_ready), 512'(0));
    check("reset valid32", 512'(s_valid_o), 512'(0));
    check("reset h_o32", 512'(s_h_o), 512'(0));
    check("reset valid64", 512'(b_valid_o), 512'(0));
    check("reset h_o64", b_h_o, 512'(0));
    rst = 1'b0;
    tick;
    check("idle ready32", 512'(s_ready), 512'(1));
    check("idle ready64", 512'(b_ready), 512'(1));

    // Reference model pinned against the RFC 7693 digests.
    check("model abc32", model_f(h_init(32), m16_t'(64'h00636261), 64'd3, 64'd0, 1'b1, 32),
          dig_words(512'(D_ABC32), 32, 32));
    check("model empty32", model_f(h_init(32), '0, 64'd0, 64'd0, 1'b1, 32),
          dig_words(512'(D_EMP32), 32, 32));
    check("model abc64", model_f(h_init(64), m16_t'(64'h636261), 64'd3, 64'd0, 1'b1, 64),
          dig_words(D_ABC64, 64, 64));

    s_ready_i = 1; b_ready_i = 1;

    send32(h_to32(h_init(32)), 512'h00636261, 64'd3, 1'b1, acc1);
    wait_valid32(lat);
    check("latency abc32", 512'(lat), 512'(80));
    check("digest abc32", h_from32(s_h_o), dig_words(512'(D_ABC32), 32, 32));
    tick;
    check("handshake valid32", 512'(s_valid_o), 512'(0));
    check("handshake ready32", 512'(s_ready), 512'(1));

    send32(h_to32(h_init(32)), '0, 64'd0, 1'b1, acc1);
    wait_valid32(lat);
    check("latency empty32", 512'(lat), 512'(80));
    check("digest empty32", h_from32(s_h_o), dig_words(512'(D_EMP32), 32, 32));

    send64(h_init(64), 1024'h636261, 128'd3, 1'b1);
    wait_valid64(lat);
    check("latency abc64", 512'(lat), 512'(96));
    check("digest abc64", b_h_o, dig_words(D_ABC64, 64, 64));

    // Backpressure: output held, inputs ignored while DONE.
    s_ready_i = 0;
    send32(h_to32(h_init(32)), 512'h00636261, 64'd3, 1'b1, acc1);
    wait_valid32(lat);
    check("latency bp32", 512'(lat), 512'(80));
    for (int i = 0; i < 20; i++) begin
      s_valid = i[0];
      for (int j = 0; j < 8; j++)  s_h[j*32 +: 32] = $urandom;
      for (int j = 0; j < 16; j++) s_m[j*32 +: 32] = $urandom;
      s_t = {$urandom, $urandom};
      s_f = i[1];
      tick;
      check("bp ready32", 512'(s_ready), 512'(0));
      check("bp hold32", h_from32(s_h_o), dig_words(512'(D_ABC32), 32, 32));
    end
    s_valid = 0;
    s_ready_i = 1;
    tick;
    check("bp release ready32", 512'(s_ready), 512'(1));
    check("bp release valid32", 512'(s_valid_o), 512'(0));

    // Reset mid-block: aborted block never produces an output.
    send32(h_to32(h_init(32)), 512'h00636261, 64'd3, 1'b1, acc1);
    quiet = 1;
    repeat (40) begin tick; if (s_valid_o) quiet = 0; end
    rst = 1;
    tick;
    check("rst ready32", 512'(s_ready), 512'(0));
    check("rst h_o32", 512'(s_h_o), 512'(0));
    rst = 0;
    repeat (100) begin tick; if (s_valid_o) quiet = 0; end
    check("abort silent32", 512'(quiet), 512'(1));
    send32(h_to32(h_init(32)), '0, 64'd0, 1'b1, acc1);
    wait_valid32(lat);
    check("latency post-rst", 512'(lat), 512'(80));
    check("digest post-rst", h_from32(s_h_o), dig_words(512'(D_EMP32), 32, 32));

    // Back-to-back two-block chain with h_o fed back.
    for (int j = 0; j < 16; j++) m1[j*32 +: 32] = 32'h03020100 + 32'(j) * 32'h04040404;
    m2 = 512'h00636261;
    e1 = model_f(h_init(32), m_from32(m1), 64'd64, 64'd0, 1'b0, 32);
    e2 = model_f(e1, m_from32(m2), 64'd67, 64'd0, 1'b1, 32);
    send32(h_to32(h_init(32)), m1, 64'd64, 1'b0, acc1);
    wait_valid32(lat);
    check("b2b first", h_from32(s_h_o), e1);
    send32(s_h_o, m2, 64'd67, 1'b1, acc2);
    check("b2b spacing", 512'(acc2 - acc1), 512'(82));
    wait_valid32(lat);
    check("b2b second", h_from32(s_h_o), e2);
    tick;

    mon_on = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
